// File: rtl/reset_seq_defs.sv
// Shared definitions for the reset sequencer: FSM state encoding and a
// counter-width helper used to size the stage index and gap counter.
package reset_seq_defs;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_e;

  // Index width for a count of n values, never narrower than one bit.
  function automatic int unsigned min1Clog2(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_sequencer_sync_bit.sv
// Single-bit synchroniser: STAGES-deep flop chain with asynchronous active-low clear.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic resetN,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) chain <= '0;
    else         chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Lock-qualified reset stretcher with staged release of NUM_DOMAINS domain resets.
// Optional saturating lock-loss counter enabled by defining LOCK_LOSS_COUNT_EN.
module reset_sequencer
  import reset_seq_defs::*;
#(
  parameter int unsigned NUM_DOMAINS   = 3,
  parameter int unsigned STRETCH_WIDTH = 24,
  parameter int unsigned STAGE_GAP     = 16,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   dcmLocked,
  input  logic                   softResetReq,
  output logic [NUM_DOMAINS-1:0] resetOut,
  output logic                   ready,
  output logic [7:0]             lockLossCount
);

  localparam int unsigned STAGE_W = min1Clog2(NUM_DOMAINS);
  localparam int unsigned GAP_W   = min1Clog2(STAGE_GAP);

  seq_state_e               state, stateNext;
  logic [STRETCH_WIDTH-1:0] cnt, cntNext;
  logic [GAP_W-1:0]         gap, gapNext;
  logic [STAGE_W-1:0]       stage, stageNext;
  logic [NUM_DOMAINS-1:0]   resetOutNext;
  logic                     readyNext;
  logic                     lockS;

  sync_bit #(.STAGES(SYNC_STAGES)) lockSync (
    .clk    (clk),
    .resetN (resetN),
    .d      (dcmLocked),
    .q      (lockS)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= HOLD;
      cnt      <= '0;
      gap      <= '0;
      stage    <= '0;
      resetOut <= '1;
      ready    <= 1'b0;
    end else begin
      state    <= stateNext;
      cnt      <= cntNext;
      gap      <= gapNext;
      stage    <= stageNext;
      resetOut <= resetOutNext;
      ready    <= readyNext;
    end
  end

  always_comb begin
    stateNext    = state;
    cntNext      = cnt;
    gapNext      = gap;
    stageNext    = stage;
    resetOutNext = resetOut;
    readyNext    = ready;
    // Soft request and lock loss share one path; the request also keeps HOLD for a cycle.
    if (softResetReq || (state != HOLD && !lockS)) begin
      stateNext    = HOLD;
      cntNext      = '0;
      gapNext      = '0;
      stageNext    = '0;
      resetOutNext = '1;
      readyNext    = 1'b0;
    end else begin
      case (state)
        HOLD: begin
          resetOutNext = '1;
          readyNext    = 1'b0;
          if (lockS) begin
            stateNext = STRETCH;
            cntNext   = '0;
          end
        end
        STRETCH: begin
          if (cnt != '1) begin
            cntNext = cnt + 1'b1;
          end else begin
            resetOutNext[0] = 1'b0;
            gapNext         = '0;
            if (NUM_DOMAINS == 1) begin
              stateNext = RUN;
              readyNext = 1'b1;
              stageNext = '0;
            end else begin
              stateNext = RELEASE;
              stageNext = STAGE_W'(1);
            end
          end
        end
        RELEASE: begin
          if (gap == GAP_W'(STAGE_GAP - 1)) begin
            resetOutNext[stage] = 1'b0;
            gapNext             = '0;
            if (stage == STAGE_W'(NUM_DOMAINS - 1)) begin
              stateNext = RUN;
              readyNext = 1'b1;
            end else begin
              stageNext = stage + 1'b1;
            end
          end else begin
            gapNext = gap + 1'b1;
          end
        end
        RUN: begin
          resetOutNext = '0;
          readyNext    = 1'b1;
        end
        default: stateNext = HOLD;
      endcase
    end
  end

`ifdef LOCK_LOSS_COUNT_EN
  logic       lockSD;
  logic [7:0] lossCnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      lockSD  <= 1'b0;
      lossCnt <= '0;
    end else begin
      lockSD <= lockS;
      if (lockSD && !lockS && state != HOLD && lossCnt != 8'hFF)
        lossCnt <= lossCnt + 1'b1;
    end
  end

  assign lockLossCount = lossCnt;
`else
  assign lockLossCount = 8'h00;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed + randomized bench for reset_sequencer against a cycle-count reference model.
module tb_reset_sequencer;

  localparam int ND = 3;
  localparam int SW = 4;
  localparam int GAP = 3;
  localparam int SYNC = 2;
  localparam int STRETCH_LEN = 1 << SW;

  logic          clk = 1'b0;
  logic          resetN;
  logic          dcmLocked;
  logic          softResetReq;
  logic [ND-1:0] resetOut;
  logic          ready;
  logic [7:0]    lockLossCount;

  int tests = 0;
  int fails = 0;

  // Reference model: seqAge = cycles since the stretch began (-1 while held).
  int seqAge;
  bit lockPipe[SYNC];
  bit lockPrev;
  int lossModel;

  reset_sequencer #(
    .NUM_DOMAINS   (ND),
    .STRETCH_WIDTH (SW),
    .STAGE_GAP     (GAP),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .dcmLocked     (dcmLocked),
    .softResetReq  (softResetReq),
    .resetOut      (resetOut),
    .ready         (ready),
    .lockLossCount (lockLossCount)
  );

  always #5 clk = ~clk;

  function automatic int releasedCount(input int age);
    int k;
    if (age < STRETCH_LEN) return 0;
    k = 1 + (age - STRETCH_LEN) / GAP;
    return (k > ND) ? ND : k;
  endfunction

  function automatic logic [ND-1:0] expOut();
    logic [ND-1:0] ones;
    ones = '1;
    return ones << releasedCount(seqAge);
  endfunction

  function automatic logic [7:0] expLoss();
`ifdef LOCK_LOSS_COUNT_EN
    return 8'(lossModel);
`else
    return 8'h00;
`endif
  endfunction

  task automatic modelReset();
    seqAge = -1;
    for (int i = 0; i < SYNC; i++) lockPipe[i] = 1'b0;
    lockPrev  = 1'b0;
    lossModel = 0;
  endtask

  task automatic modelEdge();
    bit ls;
    if (!resetN) begin
      modelReset();
      return;
    end
    ls = lockPipe[SYNC-1];
    if (lockPrev && !ls && seqAge >= 0 && lossModel < 255) lossModel++;
    lockPrev = ls;
    if (softResetReq || !ls)   seqAge = -1;
    else if (seqAge < 0)       seqAge = 0;
    else if (seqAge < 100000)  seqAge++;
    for (int i = SYNC - 1; i > 0; i--) lockPipe[i] = lockPipe[i-1];
    lockPipe[0] = dcmLocked;
  endtask

  task automatic check(input string tag);
    tests++;
    assert (resetOut === expOut()) else begin
      fails++;
      $error("FAIL %s resetOut got %b exp %b", tag, resetOut, expOut());
    end
    tests++;
    assert (ready === (releasedCount(seqAge) == ND)) else begin
      fails++;
      $error("FAIL %s ready got %b exp %b", tag, ready, releasedCount(seqAge) == ND);
    end
    tests++;
    assert (lockLossCount === expLoss()) else begin
      fails++;
      $error("FAIL %s lockLossCount got %h exp %h", tag, lockLossCount, expLoss());
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    modelEdge();
    #1;
    check(tag);
  endtask

  task automatic waitOut(input logic [ND-1:0] target, input int budget, input string tag);
    int n = 0;
    while (resetOut !== target && n < budget) begin
      tick(tag);
      n++;
    end
    tests++;
    assert (resetOut === target) else begin
      fails++;
      $error("FAIL %s timeout resetOut got %b exp %b", tag, resetOut, target);
    end
  endtask

  initial begin
    resetN = 1'b0;
    dcmLocked = 1'b1;
    softResetReq = 1'b0;
    modelReset();

    // 1. Power-up and first full sequence.
    repeat (5) tick("powerup_reset");
    resetN = 1'b1;
    repeat (30) tick("powerup_seq");
    tests++;
    assert (resetOut === 3'b000 && ready === 1'b1) else begin
      fails++;
      $error("FAIL powerup_final resetOut got %b ready %b exp 000/1", resetOut, ready);
    end

    // 2. Lock loss in RUN, then relock.
    dcmLocked = 1'b0;
    repeat (5) tick("lockloss_run");
    dcmLocked = 1'b1;
    waitOut(3'b000, 40, "relock_run");

    // 3. Lock loss in RELEASE after first bit released.
    dcmLocked = 1'b0;
    repeat (4) tick("drop_for_release");
    dcmLocked = 1'b1;
    waitOut(3'b110, 40, "reach_release");
    dcmLocked = 1'b0;
    repeat (4) tick("lockloss_release");
    dcmLocked = 1'b1;
    repeat (30) tick("rerelease");

    // 4. Soft reset in RUN.
    softResetReq = 1'b1;
    tick("soft_req");
    softResetReq = 1'b0;
    repeat (30) tick("soft_resequence");

    // 5. Async reset mid-stretch at cnt=7.
    dcmLocked = 1'b0;
    repeat (4) tick("drop_for_async");
    dcmLocked = 1'b1;
    begin
      int n = 0;
      while (seqAge != 7 && n < 40) begin
        tick("reach_cnt7");
        n++;
      end
      tests++;
      assert (seqAge == 7) else begin
        fails++;
        $error("FAIL reach_cnt7 timeout model age %0d exp 7", seqAge);
      end
    end
    #2 resetN = 1'b0;
    #1;
    tests++;
    assert (resetOut === 3'b111 && ready === 1'b0 && lockLossCount === 8'h00) else begin
      fails++;
      $error("FAIL async_reset resetOut got %b ready %b cnt %h exp 111/0/00",
             resetOut, ready, lockLossCount);
    end
    modelReset();
    repeat (2) tick("async_hold");
    resetN = 1'b1;
    repeat (30) tick("after_async");

    // Randomized lock and soft-request traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) dcmLocked = ~dcmLocked;
      softResetReq = ($urandom_range(0, 49) == 0);
      tick("random");
    end
    softResetReq = 1'b0;
    dcmLocked = 1'b1;
    repeat (30) tick("random_settle");

    // 6. Lock-loss counter saturation.
    for (int i = 0; i < 260; i++) begin
      dcmLocked = 1'b1;
      repeat (4) tick("sat_up");
      dcmLocked = 1'b0;
      repeat (4) tick("sat_down");
    end
    tests++;
`ifdef LOCK_LOSS_COUNT_EN
    assert (lockLossCount === 8'hFF) else begin
      fails++;
      $error("FAIL saturate lockLossCount got %h exp ff", lockLossCount);
    end
`else
    assert (lockLossCount === 8'h00) else begin
      fails++;
      $error("FAIL saturate lockLossCount got %h exp 00", lockLossCount);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
